jtsdram_seq: RTL and testbench

Top-level test sequencer for the SDRAM tester. On a start request it triggers the bank programmer to fill all four banks, then enables the per-bank read checkers. It counts complete verification passes and declares pass, fail or timeout. It sits between the user/OSD inputs and the programmer plus the four bank checkers, and owns their sequencing.

---
 rtl/jtsdram_seq_if.sv | 26 ++
 rtl/jtsdram_seq.sv | 180 ++++++++++++++++++
 tb/tb_jtsdram_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/jtsdram_seq_if.sv
// Signal bundle between the SDRAM test sequencer and its surroundings:
// user start, programmer handshake, bank checker lanes and OSD status.
interface jtsdram_seq_if;
    logic       start_i;
    logic       prog_start_o;
    logic       dwnld_busy_i;
    logic       prog_done_i;
    logic [3:0] bank_en_o;
    logic [3:0] bank_cycle_i;
    logic [3:0] bank_bad_i;
    logic [2:0] st_o;
    logic [7:0] pass_cnt_o;
    logic [3:0] bad_o;
    logic       timeout_o;
    logic       busy_o;

    modport master (
        input  start_i, dwnld_busy_i, prog_done_i, bank_cycle_i, bank_bad_i,
        output prog_start_o, bank_en_o, st_o, pass_cnt_o, bad_o, timeout_o, busy_o
    );

    modport slave (
        output start_i, dwnld_busy_i, prog_done_i, bank_cycle_i, bank_bad_i,
        input  prog_start_o, bank_en_o, st_o, pass_cnt_o, bad_o, timeout_o, busy_o
    );
endinterface

// File: rtl/jtsdram_seq.sv
// SDRAM tester sequencer: programs all banks, waits a settle gap, then runs the
// bank checkers until enough full passes complete, a mismatch, or the watchdog fires.
module jtsdram_seq #(
    parameter int unsigned PASSES = 8,
    parameter int unsigned SETTLE = 16,
    parameter int unsigned TOW    = 24,
    parameter logic [3:0]  BAMASK = 4'hF
) (
    input logic           clk,
    input logic           rst,
    jtsdram_seq_if.master io
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PROG   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_OK     = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    localparam logic [7:0]     PASS_TARGET = 8'(PASSES);
    localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [TOW-1:0] WDOG_ONE    = TOW'(1);

    state_t         state_q, state_d;
    logic           prog_start_q, prog_start_d;
    logic [3:0]     bank_en_q, bank_en_d;
    logic [7:0]     pass_cnt_q, pass_cnt_d;
    logic [3:0]     bad_q, bad_d;
    logic           timeout_q, timeout_d;
    logic           busy_q, busy_d;
    logic [3:0]     seen_q, seen_d;
    logic           armed_q, armed_d;
    logic [7:0]     settle_cnt_q, settle_cnt_d;
    logic [TOW-1:0] wdog_q, wdog_d;
    logic           dwnld_prev_q, done_prev_q;

    logic [3:0] cycle_hit, bad_hit, seen_next;
    logic [7:0] pass_inc;
    logic       pass_done, wdog_clr, wdog_full;

    always_comb begin
        cycle_hit = io.bank_cycle_i & BAMASK;
        bad_hit   = io.bank_bad_i & BAMASK;
        seen_next = seen_q | cycle_hit;
        pass_done = (seen_next == BAMASK);
        pass_inc  = pass_cnt_q + 8'd1;
        wdog_full = &wdog_q;
        // Any sign of life from the programmer or a checker restarts the watchdog
        wdog_clr  = (io.dwnld_busy_i & ~dwnld_prev_q) | (io.prog_done_i & ~done_prev_q) | (|cycle_hit);

        state_d      = state_q;
        prog_start_d = 1'b0;
        bank_en_d    = bank_en_q;
        pass_cnt_d   = pass_cnt_q;
        bad_d        = bad_q;
        timeout_d    = timeout_q;
        seen_d       = seen_q;
        armed_d      = armed_q;
        settle_cnt_d = settle_cnt_q;
        wdog_d       = wdog_q;

        if (io.start_i) begin
            state_d      = ST_PROG;
            prog_start_d = 1'b1;
            bank_en_d    = 4'h0;
            pass_cnt_d   = 8'd0;
            bad_d        = 4'h0;
            timeout_d    = 1'b0;
            seen_d       = 4'h0;
            armed_d      = 1'b0;
            settle_cnt_d = 8'd0;
            wdog_d       = '0;
        end else begin
            case (state_q)
                ST_PROG: begin
                    if (io.dwnld_busy_i) armed_d = 1'b1;
                    // prog_done only counts once this run has seen the programmer busy
                    if (io.prog_done_i && armed_q) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = 8'd0;
                        wdog_d       = '0;
                    end else if (wdog_clr) begin
                        wdog_d = '0;
                    end else if (wdog_full) begin
                        state_d   = ST_FAIL;
                        timeout_d = 1'b1;
                        wdog_d    = '0;
                    end else begin
                        wdog_d = wdog_q + WDOG_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d      = ST_CHECK;
                        bank_en_d    = BAMASK;
                        settle_cnt_d = 8'd0;
                        seen_d       = 4'h0;
                        wdog_d       = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end
                ST_CHECK: begin
                    seen_d = pass_done ? 4'h0 : seen_next;
                    if (pass_done) pass_cnt_d = pass_inc;
                    if (|bad_hit) begin
                        bad_d     = bad_q | bad_hit;
                        state_d   = ST_FAIL;
                        bank_en_d = 4'h0;
                        wdog_d    = '0;
                    end else if (pass_done && (pass_inc == PASS_TARGET)) begin
                        state_d   = ST_OK;
                        bank_en_d = 4'h0;
                        wdog_d    = '0;
                    end else if (wdog_clr) begin
                        wdog_d = '0;
                    end else if (wdog_full) begin
                        state_d   = ST_FAIL;
                        timeout_d = 1'b1;
                        bank_en_d = 4'h0;
                        wdog_d    = '0;
                    end else begin
                        wdog_d = wdog_q + WDOG_ONE;
                    end
                end
                ST_IDLE, ST_OK, ST_FAIL: begin
                    wdog_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    wdog_d  = '0;
                end
            endcase
        end

        busy_d = (state_d == ST_PROG) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prog_start_q <= 1'b0;
            bank_en_q    <= 4'h0;
            pass_cnt_q   <= 8'd0;
            bad_q        <= 4'h0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            seen_q       <= 4'h0;
            armed_q      <= 1'b0;
            settle_cnt_q <= 8'd0;
            wdog_q       <= '0;
            dwnld_prev_q <= 1'b0;
            done_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_start_q <= prog_start_d;
            bank_en_q    <= bank_en_d;
            pass_cnt_q   <= pass_cnt_d;
            bad_q        <= bad_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            seen_q       <= seen_d;
            armed_q      <= armed_d;
            settle_cnt_q <= settle_cnt_d;
            wdog_q       <= wdog_d;
            dwnld_prev_q <= io.dwnld_busy_i;
            done_prev_q  <= io.prog_done_i;
        end
    end

    assign io.st_o         = state_q;
    assign io.prog_start_o = prog_start_q;
    assign io.bank_en_o    = bank_en_q;
    assign io.pass_cnt_o   = pass_cnt_q;
    assign io.bad_o        = bad_q;
    assign io.timeout_o    = timeout_q;
    assign io.busy_o       = busy_q;
endmodule

// File: tb/tb_jtsdram_seq.sv
// Directed bench for jtsdram_seq: one full-mask instance for the normal flow,
// a two-bank instance with a short watchdog for the timeout path.
module tb_jtsdram_seq;
    logic clk;
    logic rst;
    int   testCount;
    int   failCount;

    jtsdram_seq_if busA ();
    jtsdram_seq_if busB ();

    jtsdram_seq #(.PASSES(2), .SETTLE(4), .TOW(24), .BAMASK(4'hF)) dutA (
        .clk (clk),
        .rst (rst),
        .io  (busA.master)
    );

    jtsdram_seq #(.PASSES(2), .SETTLE(4), .TOW(6), .BAMASK(4'h3)) dutB (
        .clk (clk),
        .rst (rst),
        .io  (busB.master)
    );

    // Status snapshot: {st, prog_start, bank_en, pass_cnt, bad, timeout, busy}
    logic [21:0] statA, statB;
    assign statA = {busA.st_o, busA.prog_start_o, busA.bank_en_o, busA.pass_cnt_o,
                    busA.bad_o, busA.timeout_o, busA.busy_o};
    assign statB = {busB.st_o, busB.prog_start_o, busB.bank_en_o, busB.pass_cnt_o,
                    busB.bad_o, busB.timeout_o, busB.busy_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] packStatus(input logic [2:0] st, input logic ps,
                                               input logic [3:0] en, input logic [7:0] pc,
                                               input logic [3:0] bd, input logic to,
                                               input logic bz);
        return {st, ps, en, pc, bd, to, bz};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit toB, input logic start, input logic dwnld,
                                 input logic done, input logic [3:0] cyc, input logic [3:0] bb);
        if (toB) begin
            busB.start_i      = start;
            busB.dwnld_busy_i = dwnld;
            busB.prog_done_i  = done;
            busB.bank_cycle_i = cyc;
            busB.bank_bad_i   = bb;
        end else begin
            busA.start_i      = start;
            busA.dwnld_busy_i = dwnld;
            busA.prog_done_i  = done;
            busA.bank_cycle_i = cyc;
            busA.bank_bad_i   = bb;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [21:0] observed, input logic [21:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %06h expected %06h", tag, observed, expected);
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        #2;
        checkOutput("resetA", statA, packStatus(3'd0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b0));
        checkOutput("resetB", statB, packStatus(3'd0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b0));
        tick(1);
        rst = 1'b0;
        tick(1);
        checkOutput("idleA", statA, packStatus(3'd0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b0));

        // Normal run to OK
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(1);
        checkOutput("t1Start", statA, packStatus(3'd1, 1'b1, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(1);
        checkOutput("t1Pulse", statA, packStatus(3'd1, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        tick(10);
        checkOutput("t1ProgBusy", statA, packStatus(3'd1, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        tick(1);
        checkOutput("t1Settle", statA, packStatus(3'd2, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(3);
        checkOutput("t1SettleHold", statA, packStatus(3'd2, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        tick(1);
        checkOutput("t1Check", statA, packStatus(3'd3, 1'b0, 4'hF, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'h0);
        tick(1);
        checkOutput("t1Partial", statA, packStatus(3'd3, 1'b0, 4'hF, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 4'h0);
        tick(1);
        checkOutput("t1Pass1", statA, packStatus(3'd3, 1'b0, 4'hF, 8'd1, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0);
        tick(1);
        checkOutput("t1Ok", statA, packStatus(3'd4, 1'b0, 4'h0, 8'd2, 4'h0, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(2);
        checkOutput("t1Hold", statA, packStatus(3'd4, 1'b0, 4'h0, 8'd2, 4'h0, 1'b0, 1'b0));

        // Stale prog_done held from the start must wait for dwnld_busy
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
        tick(1);
        checkOutput("t2Start", statA, packStatus(3'd1, 1'b1, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        tick(4);
        checkOutput("t2Stale", statA, packStatus(3'd1, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        tick(1);
        checkOutput("t2Armed", statA, packStatus(3'd1, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        tick(1);
        checkOutput("t2Settle", statA, packStatus(3'd2, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(4);
        checkOutput("t2Check", statA, packStatus(3'd3, 1'b0, 4'hF, 8'd0, 4'h0, 1'b0, 1'b1));

        // Mismatch in the same cycle as a completing pass
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4);
        tick(1);
        checkOutput("t3BadWithPass", statA, packStatus(3'd5, 1'b0, 4'h0, 8'd1, 4'h4, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h2);
        tick(1);
        checkOutput("t3BadIgnored", statA, packStatus(3'd5, 1'b0, 4'h0, 8'd1, 4'h4, 1'b0, 1'b0));

        // Restart from CHECK, then async reset mid-PROG
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(1);
        checkOutput("t5Start", statA, packStatus(3'd1, 1'b1, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0);
        tick(1);
        checkOutput("t5Pass1", statA, packStatus(3'd3, 1'b0, 4'hF, 8'd1, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(1);
        checkOutput("t5Restart", statA, packStatus(3'd1, 1'b1, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        tick(1);
        checkOutput("t5Prog", statA, packStatus(3'd1, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        #3;
        rst = 1'b1;
        #1;
        checkOutput("t5AsyncRst", statA, packStatus(3'd0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(2);
        checkOutput("t5RstHold", statA, packStatus(3'd0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b0));
        rst = 1'b0;
        tick(1);
        checkOutput("t5Idle", statA, packStatus(3'd0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b0));

        // Two-bank instance: only unmasked banks report, watchdog must expire
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(1);
        checkOutput("t4Start", statB, packStatus(3'd1, 1'b1, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        tick(1);
        checkOutput("t4Settle", statB, packStatus(3'd2, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(4);
        checkOutput("t4Check", statB, packStatus(3'd3, 1'b0, 4'h3, 8'd0, 4'h0, 1'b0, 1'b1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 4'h8);
        tick(63);
        checkOutput("t4WdogEdge", statB, packStatus(3'd3, 1'b0, 4'h3, 8'd0, 4'h0, 1'b0, 1'b1));
        tick(1);
        checkOutput("t4Timeout", statB, packStatus(3'd5, 1'b0, 4'h0, 8'd0, 4'h0, 1'b1, 1'b0));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(2);
        checkOutput("t4Hold", statB, packStatus(3'd5, 1'b0, 4'h0, 8'd0, 4'h0, 1'b1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
